vector_wb_arbiter: RTL and testbench

Write-back stage directly upstream of the vector register file (veggie) write port. Accepts completed results from NUM_SRC producers (VALU lanes, mask unit, load path), buffers each in a small per-source FIFO, and grants one masked register write per cycle by round-robin. Pulses a write-back-done event to the scoreboard for every retired result.

---
 rtl/vector_pkg.sv | 31 +++
 rtl/vector_if.sv | 24 ++
 rtl/vector_wb_fifo.sv | 58 +++++
 rtl/vector_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_vector_wb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector write-back path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package vector_pkg;

  localparam int NUM_ELEMENTS  = 32;
  localparam int ELEM_W        = 16;
  localparam int VSEL_W        = 6;
  localparam int VREG_W        = NUM_ELEMENTS * ELEM_W;
  localparam int NUM_WB_SRC    = 3;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_SRC_W      = (NUM_WB_SRC > 1) ? $clog2(NUM_WB_SRC) : 1;

  typedef logic [VSEL_W-1:0] vsel_t;
  typedef logic [VREG_W-1:0] vreg_t;

  // One completed result waiting for the register-file write port.
  typedef struct packed {
    vsel_t                   vd;
    vreg_t                   data;
    logic [NUM_ELEMENTS-1:0] mask;
  } wb_req_t;

  // Retire notification sent to the scoreboard.
  typedef struct packed {
    logic                valid;
    vsel_t               vd;
    logic [WB_SRC_W-1:0] src;
  } wb_done_t;

endpackage

// File: rtl/vector_if.sv
// Bundle of write-back signals between producers, arbiter and register file.
// Latency: n/a (wiring only).
// Backpressure: wb_in_rdy per producer, wb_out_rdy from the register file.
interface vector_if;
  import vector_pkg::*;

  wb_req_t                 wb_in [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0]   wb_in_vld;
  logic [NUM_WB_SRC-1:0]   wb_in_rdy;
  wb_req_t                 wb_out;
  logic                    wb_out_vld;
  logic                    wb_out_rdy;
  wb_done_t                wb_done;

  modport wb_arb (
    input  wb_in,
    input  wb_in_vld,
    output wb_in_rdy,
    output wb_out,
    output wb_out_vld,
    input  wb_out_rdy,
    output wb_done
  );
endinterface

// File: rtl/vector_wb_fifo.sv
// Small synchronous FIFO holding write-back requests from one producer.
// Latency: an entry pushed in cycle N is visible at head from cycle N+1.
// Backpressure: full is purely registered; push while full and pop while empty are ignored.
module vector_wb_fifo
  import vector_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output wb_req_t       head
);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vector_wb_arbiter.sv
// Buffers results from several producers and grants one masked VRF write per cycle, round-robin.
// Latency: accept in cycle N -> vrf_wen from N+1; wb_done one cycle after the retire.
// Backpressure: vrf_wready=0 locks the current grant with stable outputs; src_ready drops when a FIFO is full.
module vector_wb_arbiter
  import vector_pkg::*;
#(
  parameter  int NUM_SRC    = NUM_WB_SRC,
  parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC*VSEL_W-1:0]        src_vd,
  input  logic [NUM_SRC*VREG_W-1:0]        src_data,
  input  logic [NUM_SRC*NUM_ELEMENTS-1:0]  src_mask,
  output logic                             vrf_wen,
  input  logic                             vrf_wready,
  output logic [VSEL_W-1:0]                vrf_vd,
  output logic [VREG_W-1:0]                vrf_wdata,
  output logic [NUM_ELEMENTS-1:0]          vrf_wmask,
  output logic                             wb_done,
  output logic [VSEL_W-1:0]                wb_done_vd,
  output logic [SRC_W-1:0]                 wb_done_src
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [CW-1:0]      fifo_cnt  [NUM_SRC];
  wb_req_t            fifo_in   [NUM_SRC];
  wb_req_t            fifo_head [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   gnt_q;
  logic               lock;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   rr_next;
  logic               any_cand;
  logic               live;
  logic               mask_nz;
  logic               zero_drop;
  logic               accept;
  logic               retire;
  wb_req_t            head_sel;
  wb_done_t           done_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign fifo_in[g] = '{vd:   src_vd[g*VSEL_W +: VSEL_W],
                          data: src_data[g*VREG_W +: VREG_W],
                          mask: src_mask[g*NUM_ELEMENTS +: NUM_ELEMENTS]};
    // Ready comes only from registered occupancy so the producer never sees vrf_wready.
    assign src_ready[g] = !nRST && (fifo_cnt[g] != CW'(FIFO_DEPTH));
    // full duplicates the count test; it keeps the FIFO safe if the two ever disagree.
    assign push[g]      = src_valid[g] && src_ready[g] && !fifo_full[g];
    assign pop[g]       = retire && (grant == SRC_W'(g));

    vector_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (CLK),
      .rst      (nRST),
      .push     (push[g]),
      .push_dat (fifo_in[g]),
      .pop      (pop[g]),
      .full     (fifo_full[g]),
      .empty    (fifo_empty[g]),
      .count    (fifo_cnt[g]),
      .head     (fifo_head[g])
    );
  end

  // Pick the source: held grant while locked, else first non-empty FIFO from rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = rr_ptr;
    any_cand = 1'b0;
    if (lock) begin
      grant    = gnt_q;
      any_cand = !fifo_empty[gnt_q];
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_SRC;
        if (!any_cand && !fifo_empty[idx]) begin
          grant    = SRC_W'(idx);
          any_cand = 1'b1;
        end
      end
    end
  end

  assign head_sel  = fifo_head[grant];
  assign mask_nz   = |head_sel.mask;
  assign live      = any_cand && !nRST;
  assign vrf_wen   = live && mask_nz;
  // An all-zero mask writes nothing, so the entry is retired silently in the same cycle.
  assign zero_drop = live && !mask_nz;
  assign accept    = vrf_wen && vrf_wready;
  assign retire    = accept || zero_drop;
  assign rr_next   = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;

  assign vrf_vd    = vrf_wen ? head_sel.vd   : '0;
  assign vrf_wdata = vrf_wen ? head_sel.data : '0;
  assign vrf_wmask = vrf_wen ? head_sel.mask : '0;

  assign wb_done     = done_q.valid;
  assign wb_done_vd  = done_q.vd;
  assign wb_done_src = done_q.src;

  // Round-robin pointer, stall lock and registered retire notification.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      rr_ptr <= '0;
      gnt_q  <= '0;
      lock   <= 1'b0;
      done_q <= '0;
    end else begin
      done_q.valid <= retire;
      if (retire) begin
        done_q.vd  <= head_sel.vd;
        done_q.src <= grant;
        rr_ptr     <= rr_next;
        lock       <= 1'b0;
      end else if (vrf_wen) begin
        lock  <= 1'b1;
        gnt_q <= grant;
      end
    end
  end

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Directed bench for vector_wb_arbiter with a queue scoreboard and negedge monitor.
// Latency: expectations are queued at stimulus time and popped when the DUT retires.
// Backpressure: vrf_wready is driven directly by the directed sequences.
module tb_vector_wb_arbiter;
  import vector_pkg::*;

  logic                               CLK;
  logic                               nRST;
  logic [NUM_WB_SRC-1:0]              src_valid;
  logic [NUM_WB_SRC-1:0]              src_ready;
  logic [NUM_WB_SRC*VSEL_W-1:0]       src_vd;
  logic [NUM_WB_SRC*VREG_W-1:0]       src_data;
  logic [NUM_WB_SRC*NUM_ELEMENTS-1:0] src_mask;
  logic                               vrf_wen;
  logic                               vrf_wready;
  logic [VSEL_W-1:0]                  vrf_vd;
  logic [VREG_W-1:0]                  vrf_wdata;
  logic [NUM_ELEMENTS-1:0]            vrf_wmask;
  logic                               wb_done;
  logic [VSEL_W-1:0]                  wb_done_vd;
  logic [WB_SRC_W-1:0]                wb_done_src;

  typedef struct packed {
    logic [VSEL_W-1:0]       vd;
    logic [VREG_W-1:0]       data;
    logic [NUM_ELEMENTS-1:0] mask;
  } wr_t;

  typedef struct packed {
    logic [VSEL_W-1:0]   vd;
    logic [WB_SRC_W-1:0] src;
  } dn_t;

  wr_t exp_wr [$];
  dn_t exp_dn [$];
  wr_t mon_w;
  dn_t mon_d;
  int  total = 0;
  int  bad   = 0;

  vector_wb_arbiter dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_vd      (src_vd),
    .src_data    (src_data),
    .src_mask    (src_mask),
    .vrf_wen     (vrf_wen),
    .vrf_wready  (vrf_wready),
    .vrf_vd      (vrf_vd),
    .vrf_wdata   (vrf_wdata),
    .vrf_wmask   (vrf_wmask),
    .wb_done     (wb_done),
    .wb_done_vd  (wb_done_vd),
    .wb_done_src (wb_done_src)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int s, input logic [VSEL_W-1:0] vd, input logic [15:0] w,
                       input logic [NUM_ELEMENTS-1:0] m);
    src_valid[s]                            = 1'b1;
    src_vd[s*VSEL_W +: VSEL_W]              = vd;
    src_data[s*VREG_W +: VREG_W]            = {NUM_ELEMENTS{w}};
    src_mask[s*NUM_ELEMENTS +: NUM_ELEMENTS] = m;
  endtask

  task automatic expect_wr(input logic [VSEL_W-1:0] vd, input logic [15:0] w,
                           input logic [NUM_ELEMENTS-1:0] m, input logic [WB_SRC_W-1:0] s);
    wr_t e;
    dn_t d;
    e.vd   = vd;
    e.data = {NUM_ELEMENTS{w}};
    e.mask = m;
    d.vd   = vd;
    d.src  = s;
    exp_wr.push_back(e);
    exp_dn.push_back(d);
  endtask

  task automatic expect_dn(input logic [VSEL_W-1:0] vd, input logic [WB_SRC_W-1:0] s);
    dn_t d;
    d.vd  = vd;
    d.src = s;
    exp_dn.push_back(d);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_dn.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (exp_wr.size() != 0 || exp_dn.size() != 0) begin
      bad++;
      $display("FAIL %s drain: got %0d writes %0d dones outstanding want 0", name,
               exp_wr.size(), exp_dn.size());
      exp_wr.delete();
      exp_dn.delete();
    end
    tick();
  endtask

  // Scoreboard monitor: every accepted write and every wb_done pulse pops one expectation.
  always @(negedge CLK) begin
    if (!nRST && vrf_wen && vrf_wready) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL vrf_write: got unexpected vd=%0d want none", vrf_vd);
      end else begin
        mon_w = exp_wr.pop_front();
        if ({vrf_vd, vrf_wdata, vrf_wmask} !== mon_w) begin
          bad++;
          $display("FAIL vrf_write: got vd=%0d mask=%h data=%h want vd=%0d mask=%h data=%h",
                   vrf_vd, vrf_wmask, vrf_wdata, mon_w.vd, mon_w.mask, mon_w.data);
        end
      end
    end
    if (!nRST && wb_done) begin
      total++;
      if (exp_dn.size() == 0) begin
        bad++;
        $display("FAIL wb_done: got unexpected vd=%0d src=%0d want none", wb_done_vd, wb_done_src);
      end else begin
        mon_d = exp_dn.pop_front();
        if ({wb_done_vd, wb_done_src} !== mon_d) begin
          bad++;
          $display("FAIL wb_done: got vd=%0d src=%0d want vd=%0d src=%0d",
                   wb_done_vd, wb_done_src, mon_d.vd, mon_d.src);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST       = 1'b1;
    src_valid  = '0;
    src_vd     = '0;
    src_data   = '0;
    src_mask   = '0;
    vrf_wready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state
    check("reset src_ready", src_ready, 3'b000);
    check("reset vrf_wen", vrf_wen, 1'b0);
    check("reset wb_done", wb_done, 1'b0);
    check("reset wb_done_vd", wb_done_vd, 6'd0);
    check("reset wb_done_src", wb_done_src, 2'd0);

    // Single write straight after reset release
    nRST       = 1'b0;
    vrf_wready = 1'b1;
    drive(0, 6'd5, 16'h3C00, 32'hFFFF_FFFF);
    expect_wr(6'd5, 16'h3C00, 32'hFFFF_FFFF, 2'd0);
    #1;
    check("single src_ready", src_ready, 3'b111);
    check("single no bypass", vrf_wen, 1'b0);
    tick();
    src_valid = '0;
    #1;
    check("single vrf_wen", vrf_wen, 1'b1);
    check("single vrf_vd", vrf_vd, 6'd5);
    tick();
    check("single wb_done", wb_done, 1'b1);
    check("single wb_done_vd", wb_done_vd, 6'd5);
    check("single wb_done_src", wb_done_src, 2'd0);
    check("single src_ready after", src_ready, 3'b111);
    drain("single");

    // Round-robin: rr_ptr sits at 1 after the single write from src0
    drive(0, 6'd1, 16'h0101, 32'hFFFF_FFFF);
    drive(1, 6'd2, 16'h0202, 32'hFFFF_FFFF);
    drive(2, 6'd3, 16'h0303, 32'hFFFF_FFFF);
    expect_wr(6'd2, 16'h0202, 32'hFFFF_FFFF, 2'd1);
    expect_wr(6'd3, 16'h0303, 32'hFFFF_FFFF, 2'd2);
    expect_wr(6'd1, 16'h0101, 32'hFFFF_FFFF, 2'd0);
    expect_wr(6'd2, 16'h1202, 32'h0F0F_0F0F, 2'd1);
    expect_wr(6'd3, 16'h1303, 32'h0F0F_0F0F, 2'd2);
    expect_wr(6'd1, 16'h1101, 32'h0F0F_0F0F, 2'd0);
    #1;
    check("rr src_ready c0", src_ready, 3'b111);
    tick();
    drive(0, 6'd1, 16'h1101, 32'h0F0F_0F0F);
    drive(1, 6'd2, 16'h1202, 32'h0F0F_0F0F);
    drive(2, 6'd3, 16'h1303, 32'h0F0F_0F0F);
    #1;
    check("rr src_ready c1", src_ready, 3'b111);
    check("rr first grant", vrf_vd, 6'd2);
    tick();
    src_valid = '0;
    #1;
    check("rr src_ready full", src_ready, 3'b010);
    check("rr second grant", vrf_vd, 6'd3);
    drain("rr");

    // Zero-mask entry: dropped without a write, still retires, rr_ptr moves to 0
    drive(2, 6'd9, 16'hABCD, 32'h0000_0000);
    expect_dn(6'd9, 2'd2);
    tick();
    src_valid = '0;
    #1;
    check("zero vrf_wen", vrf_wen, 1'b0);
    tick();
    check("zero wb_done", wb_done, 1'b1);
    check("zero wb_done_vd", wb_done_vd, 6'd9);
    check("zero wb_done_src", wb_done_src, 2'd2);
    drain("zero");

    // Stall and lock: src1 holds the port while src0 (rr_ptr=0) and src2 arrive
    vrf_wready = 1'b0;
    drive(1, 6'd11, 16'h1111, 32'h0000_FFFF);
    tick();
    src_valid = '0;
    drive(0, 6'd10, 16'h0A0A, 32'hFFFF_FFFF);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        src_valid = '0;
        drive(2, 6'd12, 16'h2C2C, 32'hFFFF_0000);
      end
      if (c == 2) src_valid = '0;
      #1;
      check("stall vrf_wen", vrf_wen, 1'b1);
      check("stall vrf_vd", vrf_vd, 6'd11);
      check("stall vrf_wdata", vrf_wdata, {NUM_ELEMENTS{16'h1111}});
      check("stall vrf_wmask", vrf_wmask, 32'h0000_FFFF);
      if (c < 3) tick();
    end
    expect_wr(6'd11, 16'h1111, 32'h0000_FFFF, 2'd1);
    expect_wr(6'd12, 16'h2C2C, 32'hFFFF_0000, 2'd2);
    expect_wr(6'd10, 16'h0A0A, 32'hFFFF_FFFF, 2'd0);
    vrf_wready = 1'b1;
    drain("stall");

    // Backpressure: two entries fill src0, third waits until one cycle after the first pop
    vrf_wready = 1'b0;
    drive(0, 6'd20, 16'h2020, 32'hFFFF_FFFF);
    #1;
    check("bp ready e0", src_ready[0], 1'b1);
    tick();
    drive(0, 6'd21, 16'h2121, 32'hFFFF_FFFF);
    #1;
    check("bp ready e1", src_ready[0], 1'b1);
    tick();
    drive(0, 6'd22, 16'h2222, 32'hFFFF_FFFF);
    #1;
    check("bp ready full", src_ready[0], 1'b0);
    tick();
    check("bp ready held", src_ready[0], 1'b0);
    expect_wr(6'd20, 16'h2020, 32'hFFFF_FFFF, 2'd0);
    expect_wr(6'd21, 16'h2121, 32'hFFFF_FFFF, 2'd0);
    expect_wr(6'd22, 16'h2222, 32'hFFFF_FFFF, 2'd0);
    vrf_wready = 1'b1;
    #1;
    check("bp ready on pop", src_ready[0], 1'b0);
    tick();
    check("bp ready after pop", src_ready[0], 1'b1);
    tick();
    src_valid = '0;
    drain("bp");

    // Reset mid-flight: buffered entries vanish without writes or wb_done
    vrf_wready = 1'b0;
    drive(0, 6'd30, 16'h3030, 32'hFFFF_FFFF);
    drive(1, 6'd31, 16'h3131, 32'hFFFF_FFFF);
    tick();
    src_valid = '0;
    tick();
    check("mid pre-reset vrf_wen", vrf_wen, 1'b1);
    nRST = 1'b1;
    #1;
    check("mid reset src_ready", src_ready, 3'b000);
    check("mid reset vrf_wen", vrf_wen, 1'b0);
    tick();
    check("mid reset wb_done", wb_done, 1'b0);
    check("mid reset vrf_wen held", vrf_wen, 1'b0);
    nRST       = 1'b0;
    vrf_wready = 1'b1;
    #1;
    check("mid release vrf_wen", vrf_wen, 1'b0);
    check("mid release src_ready", src_ready, 3'b111);
    drive(0, 6'd40, 16'h4040, 32'hFFFF_FFFF);
    drive(1, 6'd41, 16'h4141, 32'hFFFF_FFFF);
    expect_wr(6'd40, 16'h4040, 32'hFFFF_FFFF, 2'd0);
    expect_wr(6'd41, 16'h4141, 32'hFFFF_FFFF, 2'd1);
    tick();
    src_valid = '0;
    #1;
    check("mid rr_ptr reset grant", vrf_vd, 6'd40);
    drain("mid");

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
